dict_pool: RTL and testbench
============================

# dict_pool

Byte-addressable dictionary memory pool for the ForthSuper core: it owns a single-port word memory and serves byte, half-word and word reads and writes. It also runs a hardware FIND that walks the linked dictionary and compares packed, length-prefixed names against a target string. It sits between the instruction sequencer and on-chip SPRAM and replaces the fixed 64K pool with a parametrised, handshaken engine.

## Interface
- `ASZ`, 16: byte-address width.
- `DEPTH`, 16384: memory depth in 32-bit words; addresses ≥ 4·DEPTH read as 0 and ignore writes.
- `NMAX`, 255: maximum name length in bytes.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `req` in 1: start the operation in `op`; sampled only in IDLE.
- `op` in 3: 0 NOP, 1 R1, 2 R2, 3 R4, 4 FIND, 5 W1, 6 W2, 7 W4.
- `ai` in ASZ: access address, or target-string address for FIND.
- `vi` in 32: write data (low-justified), or dictionary head entry address in `vi[ASZ-1:0]` for FIND.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `ok` out 1: valid with `done`; access accepted or name found.
- `ao` out ASZ: valid with `done`; matching entry address for FIND, else `ai`.
- `vo` out 32: valid with `done`; read data zero-extended; FIND returns the entry link word.

## Operation
- Little-endian: byte 0 is `word[7:0]`.
- Dictionary entry at address `e` (word-aligned):
  - `mem[e]` holds the link to the previous entry in bits `[ASZ-1:0]`; 0 terminates the list.
  - The name starts at `e+4`: byte 0 is the length `L`, followed by the characters.
- The target string at `ai` uses the same length-prefixed format.
- Alignment rules:
  - R1/W1 accept any `ai`.
  - R2/W2 require `ai[0]==0`.
  - R4/W4/FIND require `ai[1:0]==0`.
  - A misaligned request completes with `ok=0`, `vo=0` and no write.
- W1/W2 write only the addressed byte lanes, using `vi[7:0]` and `vi[15:0]` shifted to the lane.
- States: IDLE, RD, LINK, TGT, ENT, CMP, FIN.
- Transitions:
  - **IDLE:** `req` with R*/W* goes to RD (writes commit on this edge). `req` with FIND latches `tgt=ai` and `cur=vi`, sets word index `k=0`, and goes to LINK, or to FIN with `ok=0` if `cur==0`. NOP is ignored.
  - **RD:** capture the read data, then go to FIN.
  - **LINK:** read `mem[cur]`, then go to TGT.
  - **TGT:** read `mem[tgt+4k]`; on `k==0`, capture the link. Go to ENT.
  - **ENT:** read `mem[cur+4+4k]`, capture the target word, then go to CMP.
  - **CMP:** compare the entry word with the target word.
    - On `k==0`, the word count is `W=(L+4)>>2`, with `L` taken from the target byte 0; differing length bytes are a mismatch.
    - Bytes beyond `L` in word `W-1` are masked out of the compare.
    - Match and `k==W-1`: go to FIN with `ok=1` and `ao=cur`.
    - Match otherwise: increment `k`, then go to TGT.
    - Mismatch: set `cur=link` and `k=0`, then go to LINK, or to FIN with `ok=0`, `ao=0` if `link==0`.
  - **FIN:** pulse `done`, then go to IDLE.
- A target with `L>NMAX` completes immediately with `ok=0`.
- A target with `L==0` matches the first entry whose length byte is 0.
- `req` while `busy` is ignored, and no queueing occurs.

## Timing
- Reset values: `busy=0`, `done=0`, `ok=0`, `ao=0`, `vo=0`, state IDLE, `k=0`. Memory contents are not reset.
- Reset asserted mid-FIND aborts to IDLE with no `done` pulse.
- Memory has a 1-cycle synchronous read.
- `busy` rises on the edge that accepts `req` and falls with `done`.
- Write: `done` is asserted in the 2nd cycle after the accepting edge, and memory is updated at the accepting edge.
- Read: `done` is asserted in the 3rd cycle after the accepting edge.
- FIND latency, in cycles from the accepting edge to the `done` cycle: 2 + Σ over visited entries of (1 + 3·words compared).
- FIND with head 0: `done` in the 2nd cycle.

## Configuration
- `DICT_POOL_NOCASE_EN`
  - Defined: FIND compares name characters case-insensitively. Bytes 0x61–0x7A are folded to 0x41–0x5A on both operands; the length byte is never folded.
  - Undefined: the compare is exact bytewise, and no fold logic is instantiated.

## Test plan
- W4 `ai=0x100 vi=0xDEADBEEF`, then R1 `ai=0x102` -> `done` with `vo=0x000000AD`, `ok=1`; R2 `ai=0x101` -> `ok=0`, `vo=0`.
- W1 `ai=0x103 vi=0x55`, then R4 `ai=0x100` -> `vo=0x55ADBEEF`, with read `done` exactly 3 cycles after the accepting edge.
- Dictionary with entries 0x200 (`"DUP"`, link 0), 0x220 (`"DROP"`, link 0x200) and 0x240 (`"SWAP"`, link 0x220); target `"DUP"` at 0x400, FIND head 0x240 -> `ok=1`, `ao=0x200`, `vo=0`.
- Same dictionary, target `"OVER"` -> `ok=0`, `ao=0` after the walk; target `"DRO"` does not match `"DROP"` (length mismatch).
- Same dictionary, target `"dup"` -> with `DICT_POOL_NOCASE_EN` `ok=1`, `ao=0x200`; without it `ok=0`.
- FIND in flight: assert `rst` low for 1 cycle mid-walk -> `busy=0`, no `done`; a `req` during `busy` has no effect on the result.

Source files
------------

// File: rtl/dict_pool.sv
`default_nettype none
// dict_pool: byte-addressable word memory with R1/R2/R4/W1/W2/W4 access and a hardware
// dictionary FIND walker. Define DICT_POOL_NOCASE_EN for case-insensitive name compares.
module dict_pool #(
  parameter int ASZ   = 16,
  parameter int DEPTH = 16384,
  parameter int NMAX  = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  input  logic [2:0]     op,
  input  logic [ASZ-1:0] ai,
  input  logic [31:0]    vi,
  output logic           busy,
  output logic           done,
  output logic           ok,
  output logic [ASZ-1:0] ao,
  output logic [31:0]    vo
);
  localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] OP_NOP = 3'd0, OP_R1 = 3'd1, OP_R2 = 3'd2, OP_R4 = 3'd3,
                         OP_FIND = 3'd4, OP_W1 = 3'd5, OP_W2 = 3'd6, OP_W4 = 3'd7;

  typedef enum logic [2:0] {IDLE, RD, LINK, TGT, ENT, CMP, FIN} state_t;
  state_t state, nxt;

  logic [31:0]    mem [DEPTH];
  logic [31:0]    rdata, mdata, wdata, rd_val, rsh;
  logic           rvalid, we, ai_ok, maddr_ok;
  logic [3:0]     be;
  logic [ASZ-1:0] maddr, addr_r, tgt, cur;
  logic [DW-1:0]  widx;
  logic [2:0]     op_r;
  logic [31:0]    link_w, tw;
  logic [7:0]     len_r, len_cur;
  logic [6:0]     k, words;
  logic           hold, is_rd, is_wr, aligned, rd_op_r;
  logic           last, match, too_long;

  function automatic logic in_rng(input logic [ASZ-1:0] a);
    return 32'(a[ASZ-1:2]) < 32'(DEPTH);
  endfunction

`ifdef DICT_POOL_NOCASE_EN
  function automatic logic [7:0] fold(input logic [7:0] c, input logic keep);
    return (!keep && c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
  endfunction
`endif

  assign ai_ok    = in_rng(ai);
  assign maddr_ok = in_rng(maddr);
  assign widx     = DW'(maddr[ASZ-1:2]);
  assign mdata    = rvalid ? rdata : 32'd0;
  assign is_rd    = (op == OP_R1) || (op == OP_R2) || (op == OP_R4);
  assign is_wr    = (op == OP_W1) || (op == OP_W2) || (op == OP_W4);
  assign rd_op_r  = (op_r == OP_R1) || (op_r == OP_R2) || (op_r == OP_R4);
  assign busy     = (state != IDLE) && (state != FIN);
  assign done     = (state == FIN);

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata  <= mem[widx];
    rvalid <= maddr_ok;
  end

  always_comb begin
    case (op)
      OP_R2, OP_W2:          aligned = ~ai[0];
      OP_R4, OP_W4, OP_FIND: aligned = (ai[1:0] == 2'b00);
      default:               aligned = 1'b1;
    endcase
  end

  always_comb begin
    be    = 4'b0000;
    wdata = vi;
    case (op)
      OP_W1: begin be = 4'b0001 << ai[1:0]; wdata = {4{vi[7:0]}}; end
      OP_W2: begin be = ai[1] ? 4'b1100 : 4'b0011; wdata = {2{vi[15:0]}}; end
      OP_W4: be = 4'b1111;
      default: ;
    endcase
  end

  always_comb begin
    rsh = mdata >> {addr_r[1:0], 3'b000};
    case (op_r)
      OP_R1:   rd_val = {24'd0, rsh[7:0]};
      OP_R2:   rd_val = {16'd0, rsh[15:0]};
      default: rd_val = mdata;
    endcase
  end

  // Name length comes from the target's first byte; bytes past it are masked out.
  always_comb begin
    len_cur  = (k == 7'd0) ? tw[7:0] : len_r;
    words    = 7'((9'(len_cur) + 9'd4) >> 2);
    last     = ((k + 7'd1) == words);
    too_long = (k == 7'd0) && (32'(len_cur) > 32'(NMAX));
    match    = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (({k, 2'b00} + 9'(b)) <= {1'b0, len_cur}) begin
`ifdef DICT_POOL_NOCASE_EN
        if (fold(tw[8*b +: 8], (k == 7'd0) && (b == 0)) !=
            fold(mdata[8*b +: 8], (k == 7'd0) && (b == 0))) match = 1'b0;
`else
        if (tw[8*b +: 8] != mdata[8*b +: 8]) match = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // FIND ends through RD so its completion lines up one cycle after the final compare.
  always_comb begin
    nxt   = state;
    maddr = ai;
    we    = 1'b0;
    case (state)
      IDLE: if (req) begin
        if (op == OP_FIND) nxt = (aligned && vi[ASZ-1:0] != '0) ? LINK : RD;
        else if (op != OP_NOP) begin
          nxt = RD;
          we  = is_wr && aligned && ai_ok;
        end
      end
      RD:   begin maddr = addr_r; nxt = hold ? RD : FIN; end
      LINK: begin maddr = cur; nxt = TGT; end
      TGT:  begin maddr = tgt + ASZ'({k, 2'b00}); nxt = ENT; end
      ENT:  begin maddr = cur + ASZ'({k, 2'b00}) + ASZ'(4); nxt = CMP; end
      CMP: begin
        if (too_long)   nxt = RD;
        else if (match) nxt = last ? RD : TGT;
        else            nxt = (link_w[ASZ-1:0] == '0) ? RD : LINK;
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ok <= 1'b0; ao <= '0; vo <= '0; k <= '0; cur <= '0; tgt <= '0;
      addr_r <= '0; op_r <= OP_NOP; link_w <= '0; tw <= '0; len_r <= '0; hold <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req && op != OP_NOP) begin
          op_r   <= op;
          addr_r <= ai;
          k      <= '0;
          vo     <= '0;
          hold   <= is_rd;
          if (op == OP_FIND) begin
            tgt <= ai;
            cur <= vi[ASZ-1:0];
            ok  <= 1'b0;
            ao  <= '0;
          end else begin
            ok <= aligned;
            ao <= ai;
          end
        end
        RD: begin
          hold <= 1'b0;
          if (!hold && rd_op_r && ok) vo <= rd_val;
        end
        TGT: if (k == 7'd0) link_w <= mdata;
        ENT: tw <= mdata;
        CMP: begin
          if (k == 7'd0) len_r <= tw[7:0];
          if (!too_long) begin
            if (match) begin
              if (last) begin
                ok <= 1'b1;
                ao <= cur;
                vo <= link_w;
              end else begin
                k <= k + 7'd1;
              end
            end else begin
              cur <= link_w[ASZ-1:0];
              k   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dict_pool.sv
`default_nettype none
// tb_dict_pool: directed + randomized checks of dict_pool against a byte-array reference model.
module tb_dict_pool;
  logic        clk = 1'b0, rst = 1'b0, req = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] ai = 16'd0;
  logic [31:0] vi = 32'd0;
  logic        busy, done, ok;
  logic [15:0] ao;
  logic [31:0] vo;

  int checks = 0, errors = 0;
  byte unsigned mb [65536];
  int          r_lat;
  logic        r_ok;
  logic [15:0] r_ao;
  logic [31:0] r_vo;

  always #5 clk = ~clk;

  dict_pool dut (.clk(clk), .rst(rst), .req(req), .op(op), .ai(ai), .vi(vi),
                 .busy(busy), .done(done), .ok(ok), .ao(ao), .vo(vo));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mword(input int a);
    return {mb[(a+3) & 'hFFFF], mb[(a+2) & 'hFFFF], mb[(a+1) & 'hFFFF], mb[a & 'hFFFF]};
  endfunction

  function automatic byte unsigned fold(input byte unsigned c);
`ifdef DICT_POOL_NOCASE_EN
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
`else
    return c;
`endif
  endfunction

  // Issue one request and wait (bounded) for done; latency counts cycles after the accept edge.
  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [31:0] v);
    @(negedge clk); req = 1'b1; op = o; ai = a; vi = v;
    @(posedge clk); #1 req = 1'b0; op = 3'd0;
    r_lat = -1; r_ok = 1'bx; r_ao = 'x; r_vo = 'x;
    for (int c = 1; c <= 500; c++) begin
      @(negedge clk);
      if (done) begin r_lat = c; r_ok = ok; r_ao = ao; r_vo = vo; break; end
    end
  endtask

  task automatic do_access(input string tag, input logic [2:0] o, input int a, input logic [31:0] v);
    bit al; logic [31:0] ev;
    al = (o == 3'd2 || o == 3'd6) ? (a % 2 == 0) : (o == 3'd3 || o == 3'd7) ? (a % 4 == 0) : 1'b1;
    ev = 32'd0;
    if (al) begin
      case (o)
        3'd1: ev = {24'd0, mb[a]};
        3'd2: ev = {16'd0, mb[a+1], mb[a]};
        3'd3: ev = mword(a);
        default: ;
      endcase
    end
    run_op(o, 16'(a), v);
    if (al) begin
      case (o)
        3'd5: mb[a] = v[7:0];
        3'd6: begin mb[a] = v[7:0]; mb[a+1] = v[15:8]; end
        3'd7: for (int i = 0; i < 4; i++) mb[a+i] = v[8*i +: 8];
        default: ;
      endcase
    end
    check({tag, ".lat"}, r_lat, (o >= 3'd5) ? 2 : 3);
    check({tag, ".ok"}, {31'd0, r_ok}, {31'd0, al});
    check({tag, ".ao"}, {16'd0, r_ao}, 32'(16'(a)));
    check({tag, ".vo"}, r_vo, ev);
  endtask

  task automatic put_name(input int a, input string s);
    do_access("name", 3'd5, a, 32'(s.len()));
    for (int i = 0; i < s.len(); i++) do_access("name", 3'd5, a + 1 + i, {24'd0, s[i]});
  endtask

  // Reference FIND: walk links, compare length + characters bytewise, count words touched.
  task automatic do_find(input string tag, input int tgt, input int head);
    bit eok, hit; int eao, elat, e, lt, w; logic [31:0] evo; byte unsigned x, y;
    eok = 0; eao = 0; evo = 0; elat = 2; e = head;
    if (tgt % 4 == 0) begin
      lt = mb[tgt];
      while (e != 0 && !eok) begin
        hit = 1; w = lt / 4 + 1;
        for (int j = 0; j <= lt; j++) begin
          x = mb[(tgt + j) & 'hFFFF]; y = mb[(e + 4 + j) & 'hFFFF];
          if (j > 0) begin x = fold(x); y = fold(y); end
          if (x != y) begin hit = 0; w = j / 4 + 1; break; end
        end
        elat += 1 + 3 * w;
        if (hit) begin eok = 1; eao = e; evo = mword(e); end
        else e = int'(mword(e) & 32'h0000FFFF);
      end
    end
    run_op(3'd4, 16'(tgt), 32'(head));
    if (tgt % 4 == 0) check({tag, ".lat"}, r_lat, elat);
    else check({tag, ".lat"}, {31'd0, (r_lat > 0)}, 32'd1);
    check({tag, ".ok"}, {31'd0, r_ok}, {31'd0, eok});
    check({tag, ".ao"}, {16'd0, r_ao}, 32'(eao));
    check({tag, ".vo"}, r_vo, evo);
  endtask

  initial begin
    logic [2:0] o;
    bit seen;
    string s, alpha;
    alpha = "DUPROSWAILTdup";

    repeat (3) @(negedge clk);
    check("rst.busy", {31'd0, busy}, 0);
    check("rst.done", {31'd0, done}, 0);
    check("rst.ok", {31'd0, ok}, 0);
    check("rst.ao", {16'd0, ao}, 0);
    check("rst.vo", vo, 0);
    rst = 1'b1;

    for (int a = 'h200; a < 'h300; a += 4) do_access("init", 3'd7, a, 32'd0);
    for (int a = 'h400; a < 'h410; a += 4) do_access("init", 3'd7, a, 32'd0);
    for (int a = 'h800; a < 'h900; a += 4) do_access("init", 3'd7, a, $urandom);

    do_access("w4", 3'd7, 'h100, 32'hDEADBEEF);
    do_access("r1", 3'd1, 'h102, 32'd0);
    check("r1.const", r_vo, 32'h000000AD);
    do_access("r2mis", 3'd2, 'h101, 32'd0);
    check("r2mis.const", {31'd0, r_ok}, 0);
    do_access("w1", 3'd5, 'h103, 32'h55);
    do_access("r4", 3'd3, 'h100, 32'd0);
    check("r4.const", r_vo, 32'h55ADBEEF);
    check("r4.latconst", r_lat, 3);

    for (int n = 0; n < 40; n++) begin
      o = 3'($urandom_range(1, 6));
      if (o >= 3'd4) o = o + 3'd1;
      do_access("rand", o, 'h800 + int'($urandom_range(0, 252)), $urandom);
    end

    do_access("dict", 3'd7, 'h200, 32'd0);     put_name('h204, "DUP");
    do_access("dict", 3'd7, 'h220, 32'h200);   put_name('h224, "DROP");
    do_access("dict", 3'd7, 'h240, 32'h220);   put_name('h244, "SWAP");
    do_access("dict", 3'd7, 'h260, 32'h240);   put_name('h264, "");
    do_access("dict", 3'd7, 'h280, 32'h260);   put_name('h284, "LITERAL");
    do_access("dict", 3'd7, 'h2C0, 32'h280);   put_name('h2C4, "LITERAX");

    put_name('h400, "DUP");  do_find("f.dup", 'h400, 'h240);
    check("f.dup.ao", {16'd0, r_ao}, 32'h200);
    check("f.dup.lat", r_lat, 14);
    put_name('h400, "OVER"); do_find("f.over", 'h400, 'h240);
    check("f.over.ok", {31'd0, r_ok}, 0);
    put_name('h400, "DRO");  do_find("f.dro", 'h400, 'h240);
    check("f.dro.ok", {31'd0, r_ok}, 0);
    put_name('h400, "dup");  do_find("f.lc", 'h400, 'h240);
`ifdef DICT_POOL_NOCASE_EN
    check("f.lc.ok", {31'd0, r_ok}, 1);
`else
    check("f.lc.ok", {31'd0, r_ok}, 0);
`endif
    put_name('h400, "LITERAL"); do_find("f.lit", 'h400, 'h2C0);
    check("f.lit.ao", {16'd0, r_ao}, 32'h280);
    put_name('h400, "");     do_find("f.empty", 'h400, 'h2C0);
    check("f.empty.ao", {16'd0, r_ao}, 32'h260);
    do_find("f.null", 'h400, 0);
    check("f.null.lat", r_lat, 2);
    do_find("f.mis", 'h402, 'h2C0);

    for (int n = 0; n < 12; n++) begin
      s = "";
      for (int i = 0; i < int'($urandom_range(0, 7)); i++) begin
        s = {s, " "};
        s[s.len()-1] = alpha[$urandom_range(0, alpha.len() - 1)];
      end
      put_name('h400, s);
      do_find("f.rand", 'h400, ($urandom_range(0, 1) == 0) ? 'h240 : 'h2C0);
    end

    put_name('h400, "ZZZ");
    @(negedge clk); req = 1'b1; op = 3'd4; ai = 16'h400; vi = 32'h2C0;
    @(posedge clk); #1 req = 1'b0; op = 3'd0;
    repeat (5) @(negedge clk);
    check("abort.busy_mid", {31'd0, busy}, 1);
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    check("abort.busy", {31'd0, busy}, 0);
    seen = 0;
    repeat (30) begin @(negedge clk); if (done) seen = 1; end
    check("abort.nodone", {31'd0, seen}, 0);

    put_name('h400, "DUP");
    @(negedge clk); req = 1'b1; op = 3'd4; ai = 16'h400; vi = 32'h240;
    @(posedge clk); #1 req = 1'b0; op = 3'd0;
    r_lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 2) begin req = 1'b1; op = 3'd7; ai = 16'h800; vi = 32'hA5A5A5A5; end
      if (c == 3) begin req = 1'b0; op = 3'd0; end
      if (done) begin r_lat = c; r_ok = ok; r_ao = ao; r_vo = vo; break; end
    end
    check("busyreq.lat", r_lat, 14);
    check("busyreq.ok", {31'd0, r_ok}, 1);
    check("busyreq.ao", {16'd0, r_ao}, 32'h200);
    do_access("busyreq.rd", 3'd3, 'h800, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
